// File: rtl/jtag_retime_pkg.sv
// Shared constants for the JTAG forward retimer: vector bit positions,
// reset vector, LFSR parameters and FSM state encoding.
package jtag_retime_pkg;

   localparam int TCK_BIT = 2;
   localparam int TMS_BIT = 1;
   localparam int TDI_BIT = 0;

   localparam logic [2:0] RESET_VEC = 3'b011;

   localparam int          LFSR_W    = 16;
   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic {IDLE, WAIT} state_t;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
   endfunction

endpackage

// File: rtl/jtag_edge_fifo.sv
// Small FIFO of {tck,tms,tdi} vectors; can accept one or two entries per
// cycle and reports free slots so the writer can check space up front.
module jtag_edge_fifo
   import jtag_retime_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic                       push1,
   input  logic                       push2,
   input  logic [2:0]                 din_a,
   input  logic [2:0]                 din_b,
   input  logic                       pop,
   output logic [2:0]                 head,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     free
);

   localparam int AW = $clog2(DEPTH);

   logic [2:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   n_push;

   always_comb begin
      n_push = '0;
      if (push2)
         n_push = (AW+1)'(2);
      else if (push1)
         n_push = (AW+1)'(1);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + n_push[AW-1:0];
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + n_push - (AW+1)'(pop);
      end
   end

   // Storage carries no reset; occupancy alone says what is valid.
   always_ff @(posedge clock) begin
      if (push1 || push2)
         mem[wr_ptr] <= din_a;
      if (push2)
         mem[wr_ptr + AW'(1)] <= din_b;
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign free  = (AW+1)'(DEPTH) - count;

endmodule

// File: rtl/jtag_fwd_retimer.sv
// Re-clocks debugger TCK/TMS/TDI into the PLL domain and re-drives them to
// the target after a base delay plus optional LFSR jitter, preserving order.
module jtag_fwd_retimer
   import jtag_retime_pkg::*;
#(
   parameter int BASE_DELAY  = 2,
   parameter int JITTER_BITS = 3,
   parameter int DEPTH       = 4
) (
   input  logic clock,
   input  logic resetn,
   input  logic tck_in,
   input  logic tms_in,
   input  logic tdi_in,
   input  logic jitter_en,
   output logic tck_out,
   output logic tms_out,
   output logic tdi_out,
   output logic busy,
   output logic overrun
);

   localparam int          AW       = $clog2(DEPTH);
   localparam int          CNT_W    = $clog2(BASE_DELAY + (1 << JITTER_BITS)) + 1;
   localparam logic [15:0] JIT_MASK = 16'((1 << JITTER_BITS) - 1);

   logic [2:0]        sync1, sync2, last_vec;
   logic [2:0]        hold, out_vec, din_a, head;
   logic [AW:0]       free, need;
   logic              changed, split, fits, push1, push2, pop, empty;
   logic [LFSR_W-1:0] lfsr;
   logic [CNT_W-1:0]  cnt, load_val, jit;
   state_t            state, state_n;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1    <= RESET_VEC;
         sync2    <= RESET_VEC;
         last_vec <= RESET_VEC;
         overrun  <= 1'b0;
         lfsr     <= LFSR_SEED;
      end else begin
         sync1    <= {tck_in, tms_in, tdi_in};
         sync2    <= sync1;
         last_vec <= sync2;
         overrun  <= overrun | (changed & ~fits);
         lfsr     <= lfsr_step(lfsr);
      end
   end

   // A TCK rise that also moves TMS/TDI is split so data reaches the target
   // a full update ahead of the clock edge that samples it.
   always_comb begin
      changed = (sync2 != last_vec);
      split   = changed && sync2[TCK_BIT] && !last_vec[TCK_BIT] &&
                (sync2[TMS_BIT:TDI_BIT] != last_vec[TMS_BIT:TDI_BIT]);
      need    = split ? (AW+1)'(2) : (AW+1)'(1);
      fits    = (free >= need);
      push2   = split & fits;
      push1   = changed & ~split & fits;
      din_a   = split ? {last_vec[TCK_BIT], sync2[TMS_BIT], sync2[TDI_BIT]} : sync2;
   end

   jtag_edge_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock  (clock),
      .resetn (resetn),
      .push1  (push1),
      .push2  (push2),
      .din_a  (din_a),
      .din_b  (sync2),
      .pop    (pop),
      .head   (head),
      .empty  (empty),
      .free   (free)
   );

   always_comb begin
      jit      = jitter_en ? CNT_W'(lfsr & JIT_MASK) : '0;
      load_val = CNT_W'(BASE_DELAY) + jit;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (cnt == CNT_W'(1))
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         hold    <= RESET_VEC;
         cnt     <= '0;
         out_vec <= RESET_VEC;
      end else if (pop) begin
         hold <= head;
         cnt  <= load_val;
      end else if (state == WAIT) begin
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1))
            out_vec <= hold;
      end
   end

   assign tck_out = out_vec[TCK_BIT];
   assign tms_out = out_vec[TMS_BIT];
   assign tdi_out = out_vec[TDI_BIT];
   assign busy    = !empty || (state == WAIT);

endmodule

// File: tb/tb_jtag_fwd_retimer.sv
// Directed bench for jtag_fwd_retimer: reset, latency table, split events,
// jitter range, overrun and mid-operation reset.
module tb_jtag_fwd_retimer;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   logic tck_in = 1'b0, tms_in = 1'b1, tdi_in = 1'b1;
   logic jitter_en = 1'b0;
   logic tck_out, tms_out, tdi_out, busy, overrun;

   jtag_fwd_retimer #(.BASE_DELAY(2), .JITTER_BITS(3), .DEPTH(4)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .tck_in    (tck_in),
      .tms_in    (tms_in),
      .tdi_in    (tdi_in),
      .jitter_en (jitter_en),
      .tck_out   (tck_out),
      .tms_out   (tms_out),
      .tdi_out   (tdi_out),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #10 clock = ~clock;

   typedef struct {
      int         cyc;
      logic [2:0] v;
   } ev_t;

   typedef struct {
      logic [2:0] vin;
      logic [2:0] vexp;
      int         lat;
   } vec_t;

   ev_t        evq[$];
   int         ecount = 0;
   logic [2:0] last_out = 3'b011;
   int         n_pass = 0;
   int         n_total = 0;

   // Edge counter plus change log of the output vector, sampled after the edge.
   always @(posedge clock) begin
      ecount++;
      #1;
      if ({tck_out, tms_out, tdi_out} !== last_out) begin
         last_out = {tck_out, tms_out, tdi_out};
         evq.push_back('{ecount, last_out});
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
   endtask

   task automatic drive(input logic [2:0] v, output int k);
      @(negedge clock);
      {tck_in, tms_in, tdi_in} = v;
      k = ecount + 1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic expect_ev(input string name, input int exp_cyc, input logic [2:0] exp_v);
      ev_t e;
      if (evq.size() == 0) begin
         check({name, "_present"}, 0, 1);
      end else begin
         e = evq.pop_front();
         check({name, "_cyc"}, e.cyc, exp_cyc);
         check({name, "_val"}, int'(e.v), int'(exp_v));
      end
   endtask

   vec_t tbl[6];
   int   k, k2;
   int   d, nd;
   logic [15:0] seen;
   ev_t  e;

   initial begin
      tbl[0] = '{3'b111, 3'b111, 5};  // TCK rise alone
      tbl[1] = '{3'b011, 3'b011, 5};  // TCK fall
      tbl[2] = '{3'b001, 3'b001, 5};  // TMS fall
      tbl[3] = '{3'b000, 3'b000, 5};  // TDI fall
      tbl[4] = '{3'b100, 3'b100, 5};  // TCK rise, data steady
      tbl[5] = '{3'b011, 3'b011, 5};  // TCK fall with TMS/TDI change: one entry

      // Reset held with toggling inputs
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         {tck_in, tms_in, tdi_in} = 3'(i + 4);
      end
      check("rst_out", int'({tck_out, tms_out, tdi_out}), 3);
      check("rst_busy", int'(busy), 0);
      check("rst_overrun", int'(overrun), 0);
      @(negedge clock);
      {tck_in, tms_in, tdi_in} = 3'b011;
      idle(3);
      resetn = 1'b1;
      evq.delete();
      idle(50);
      check("rel_no_events", evq.size(), 0);
      check("rel_busy", int'(busy), 0);
      check("rel_out", int'({tck_out, tms_out, tdi_out}), 3);

      // Single-event latency table
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].vin, k);
         idle(20);
         expect_ev($sformatf("tbl%0d", i), k + tbl[i].lat, tbl[i].vexp);
         check($sformatf("tbl%0d_extra", i), evq.size(), 0);
         evq.delete();
      end

      // TDI fall with TCK rise: data first, clock three cycles later
      drive(3'b110, k);
      idle(20);
      expect_ev("split_data", k + 5, 3'b010);
      expect_ev("split_clk", k + 8, 3'b110);
      check("split_extra", evq.size(), 0);
      drive(3'b011, k);
      idle(20);
      expect_ev("split_back", k + 5, 3'b011);
      evq.delete();

      // Jitter: 64 TCK pulses, 40 cycles per pulse
      jitter_en = 1'b1;
      seen = '0;
      for (int p = 0; p < 64; p++) begin
         for (int h = 0; h < 2; h++) begin
            drive(h == 0 ? 3'b111 : 3'b011, k);
            idle(19);
            if (evq.size() == 0) begin
               check("jit_present", 0, 1);
            end else begin
               e = evq.pop_front();
               d = e.cyc - k;
               check("jit_delay_in_range", int'(d >= 5 && d <= 12), 1);
               check("jit_order", int'(e.v), h == 0 ? 7 : 3);
               if (d >= 0 && d < 16)
                  seen[d] = 1'b1;
            end
         end
      end
      nd = 0;
      for (int i = 0; i < 16; i++)
         if (seen[i]) nd++;
      check("jit_distinct_ge4", int'(nd >= 4), 1);
      jitter_en = 1'b0;
      idle(20);
      evq.delete();

      // Overrun: eight TDI toggles on consecutive cycles, six fit
      check("ovr_before", int'(overrun), 0);
      for (int i = 0; i < 8; i++) begin
         drive((i % 2 == 0) ? 3'b010 : 3'b011, k2);
         if (i == 0) k = k2;
      end
      idle(40);
      check("ovr_set", int'(overrun), 1);
      for (int i = 0; i < 6; i++)
         expect_ev($sformatf("ovr_ev%0d", i), k + 5 + 3 * i, (i % 2 == 0) ? 3'b010 : 3'b011);
      check("ovr_extra", evq.size(), 0);
      idle(50);
      check("ovr_sticky", int'(overrun), 1);
      @(negedge clock);
      resetn = 1'b0;
      #1;
      check("ovr_reset_clears", int'(overrun), 0);
      idle(2);
      resetn = 1'b1;
      idle(5);
      evq.delete();

      // Reset during WAIT with queued entries
      drive(3'b100, k);
      idle(30);
      check("mid_pre_out", int'({tck_out, tms_out, tdi_out}), 4);
      evq.delete();
      drive(3'b101, k);
      drive(3'b100, k);
      drive(3'b101, k);
      drive(3'b100, k);
      idle(2);
      check("mid_busy", int'(busy), 1);
      resetn = 1'b0;
      #1;
      check("mid_rst_out", int'({tck_out, tms_out, tdi_out}), 3);
      check("mid_rst_busy", int'(busy), 0);
      {tck_in, tms_in, tdi_in} = 3'b011;
      idle(3);
      resetn = 1'b1;
      evq.delete();
      idle(40);
      check("mid_no_late", evq.size(), 0);
      check("mid_out_after", int'({tck_out, tms_out, tdi_out}), 3);
      check("mid_busy_after", int'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
